// File: rtl/stage_id_decode_if.sv
// Bundles the decode stage's input and output signals: the instruction from
// IF/ID, flush and write-back from upstream, and the ID/EX outputs downstream.
interface stage_id_decode_if #(parameter int N = 32);
  logic [N-1:0] instruction_id_i;
  logic         clear_pipes_i;
  logic         we_wb_i;
  logic [3:0]   rd_wb_i;
  logic [N-1:0] data_wb_i;

  logic [1:0]   branchselect_id_o;
  logic         stall_o;
  logic [N-1:0] opA_ex_o;
  logic [N-1:0] opB_ex_o;
  logic [N-1:0] Extend_ex_o;
  logic [3:0]   rd_ex_o;
  logic [3:0]   alu_func_ex_o;
  logic [1:0]   branchselect_ex_o;
  logic         mem_re_ex_o;
  logic         mem_we_ex_o;
  logic         reg_we_ex_o;
  logic         valid_ex_o;

  modport master (
    output instruction_id_i, clear_pipes_i, we_wb_i, rd_wb_i, data_wb_i,
    input  branchselect_id_o, stall_o, opA_ex_o, opB_ex_o, Extend_ex_o,
           rd_ex_o, alu_func_ex_o, branchselect_ex_o, mem_re_ex_o,
           mem_we_ex_o, reg_we_ex_o, valid_ex_o
  );

  modport slave (
    input  instruction_id_i, clear_pipes_i, we_wb_i, rd_wb_i, data_wb_i,
    output branchselect_id_o, stall_o, opA_ex_o, opB_ex_o, Extend_ex_o,
           rd_ex_o, alu_func_ex_o, branchselect_ex_o, mem_re_ex_o,
           mem_we_ex_o, reg_we_ex_o, valid_ex_o
  );
endinterface

// File: rtl/stage_id_decode.sv
// Instruction decode stage: decodes the IF/ID instruction, reads the register
// file (write-through bypass from write-back), sign-extends immediates and
// registers everything into ID/EX. A load in EX whose destination feeds the
// instruction in ID produces a one-cycle stall and a bubble.
module stage_id_decode #(
  parameter int N    = 32,
  parameter int NREG = 16
) (
  input logic CLK,
  input logic RST,
  stage_id_decode_if.slave bus
);

  logic [N-1:0] instr;
  logic [1:0]   typ;
  logic [3:0]   func;
  logic [3:0]   rd;
  logic [3:0]   rn;
  logic [3:0]   rm;
  logic         is_load;
  logic         is_store;
  logic         is_imm;
  logic         reg_we;
  logic [1:0]   bclass;
  logic [N-1:0] imm18_ext;
  logic [N-1:0] imm26_ext;
  logic [N-1:0] ext_val;
  logic [3:0]   rm_port_addr;
  logic [N-1:0] rn_val;
  logic [N-1:0] rm_val;
  logic [N-1:0] opb_val;
  logic         stall;

  logic [N-1:0] regs [0:NREG-1];

  assign instr = bus.instruction_id_i;

  // Field extraction and control decode of the instruction sitting in ID
  always_comb begin
    typ      = instr[31:30];
    func     = instr[29:26];
    rd       = instr[25:22];
    rn       = instr[21:18];
    rm       = instr[17:14];
    is_load  = (typ == 2'b10) && func[0];
    is_store = (typ == 2'b10) && !func[0];
    is_imm   = (typ == 2'b01) || (typ == 2'b10);
    reg_we   = (((typ == 2'b00) || (typ == 2'b01)) && (instr != '0)) || is_load;
    bclass   = (typ == 2'b11) ? instr[27:26] : 2'b00;
    imm18_ext = {{(N-18){instr[17]}}, instr[17:0]};
    imm26_ext = {{(N-26){instr[25]}}, instr[25:0]};
    if (typ == 2'b11)
      ext_val = imm26_ext;
    else if (is_imm)
      ext_val = imm18_ext;
    else
      ext_val = '0;
    // store data comes from rd, routed through the Rm read port
    rm_port_addr = is_store ? rd : rm;
  end

  // Register file reads: R0 is hard zero, write-back data bypasses the array
  always_comb begin
    rn_val = '0;
    rm_val = '0;
    if (rn != 4'd0)
      rn_val = (bus.we_wb_i && (bus.rd_wb_i == rn)) ? bus.data_wb_i : regs[rn];
    if (rm_port_addr != 4'd0)
      rm_val = (bus.we_wb_i && (bus.rd_wb_i == rm_port_addr)) ? bus.data_wb_i : regs[rm_port_addr];
    opb_val = is_imm ? imm18_ext : rm_val;
  end

  // Load-use hazard against the load currently held in ID/EX
  always_comb begin
    stall = 1'b0;
    if (bus.valid_ex_o && bus.mem_re_ex_o && (bus.rd_ex_o != 4'd0)) begin
      if ((typ != 2'b11) && (rn == bus.rd_ex_o))
        stall = 1'b1;
      if ((typ == 2'b00) && (rm == bus.rd_ex_o))
        stall = 1'b1;
      if (is_store && (rd == bus.rd_ex_o))
        stall = 1'b1;
    end
  end

  assign bus.stall_o           = stall;
  assign bus.branchselect_id_o = stall ? 2'b00 : bclass;

  // Register file write port; R0 is never written
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (bus.we_wb_i && (bus.rd_wb_i != 4'd0)) begin
      regs[bus.rd_wb_i] <= bus.data_wb_i;
    end
  end

  // ID/EX boundary: flush or stall inserts a bubble, otherwise capture decode
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.opA_ex_o          <= '0;
      bus.opB_ex_o          <= '0;
      bus.Extend_ex_o       <= '0;
      bus.rd_ex_o           <= '0;
      bus.alu_func_ex_o     <= '0;
      bus.branchselect_ex_o <= '0;
      bus.mem_re_ex_o       <= 1'b0;
      bus.mem_we_ex_o       <= 1'b0;
      bus.reg_we_ex_o       <= 1'b0;
      bus.valid_ex_o        <= 1'b0;
    end else if (bus.clear_pipes_i || stall) begin
      bus.opA_ex_o          <= '0;
      bus.opB_ex_o          <= '0;
      bus.Extend_ex_o       <= '0;
      bus.rd_ex_o           <= '0;
      bus.alu_func_ex_o     <= '0;
      bus.branchselect_ex_o <= '0;
      bus.mem_re_ex_o       <= 1'b0;
      bus.mem_we_ex_o       <= 1'b0;
      bus.reg_we_ex_o       <= 1'b0;
      bus.valid_ex_o        <= 1'b0;
    end else begin
      bus.opA_ex_o          <= rn_val;
      bus.opB_ex_o          <= opb_val;
      bus.Extend_ex_o       <= ext_val;
      bus.rd_ex_o           <= rd;
      bus.alu_func_ex_o     <= func;
      bus.branchselect_ex_o <= bclass;
      bus.mem_re_ex_o       <= is_load;
      bus.mem_we_ex_o       <= is_store;
      bus.reg_we_ex_o       <= reg_we;
      bus.valid_ex_o        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_id_decode.sv
// Bench for the decode stage: directed scenarios followed by random traffic,
// all compared against an architectural model of the register file and the
// ID/EX contents.
module tb_stage_id_decode;

  logic clk;
  logic rst_n;

  stage_id_decode_if #(.N(32)) bus ();

  stage_id_decode #(.N(32), .NREG(16)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] ext;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [1:0]  bsel;
    logic        mre;
    logic        mwe;
    logic        rwe;
  } ex_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [16];
  ex_t         mex;
  logic        m_we;
  logic [3:0]  m_wrd;
  logic [31:0] m_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Two's-complement sign extension done arithmetically
  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    logic [31:0] half;
    half = 32'd1 << (w - 1);
    return (v ^ half) - half;
  endfunction

  function automatic logic [31:0] rreg(input int unsigned a);
    if (a == 0) return 32'd0;
    if (m_we && (int'(m_wrd) == a)) return m_wd;
    return mregs[a];
  endfunction

  function automatic ex_t model_decode(input logic [31:0] ins);
    ex_t e;
    int unsigned u, t, f, rd, rn, rm;
    bit ld, st, imm_t;
    logic [31:0] s18;
    u  = ins;
    t  = u >> 30;
    f  = (u >> 26) & 15;
    rd = (u >> 22) & 15;
    rn = (u >> 18) & 15;
    rm = (u >> 14) & 15;
    ld    = (t == 2) && (f % 2 == 1);
    st    = (t == 2) && (f % 2 == 0);
    imm_t = (t == 1) || (t == 2);
    s18   = sext(u & 32'h3FFFF, 18);
    e       = '0;
    e.valid = 1'b1;
    e.opA   = rreg(rn);
    e.opB   = imm_t ? s18 : rreg(rm);
    e.ext   = (t == 3) ? sext(u & 32'h3FFFFFF, 26) : (imm_t ? s18 : 32'd0);
    e.rd    = rd[3:0];
    e.func  = f[3:0];
    e.bsel  = (t == 3) ? f[1:0] : 2'b00;
    e.mre   = ld;
    e.mwe   = st;
    e.rwe   = ((t <= 1) && (u != 0)) || ld;
    return e;
  endfunction

  function automatic logic model_stall(input logic [31:0] ins);
    int unsigned u, t, f, srcs[$];
    u = ins;
    t = u >> 30;
    f = (u >> 26) & 15;
    if (t != 3) srcs.push_back((u >> 18) & 15);
    if (t == 0) srcs.push_back((u >> 14) & 15);
    if ((t == 2) && (f % 2 == 0)) srcs.push_back((u >> 22) & 15);
    if (!mex.valid || !mex.mre || (mex.rd == 4'd0)) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == int'(mex.rd)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mk(input int unsigned t, input int unsigned f,
                                     input int unsigned rd, input int unsigned rn,
                                     input logic [17:0] low);
    return {t[1:0], f[3:0], rd[3:0], rn[3:0], low};
  endfunction

  function automatic logic [31:0] mk_alu(input int unsigned rd, input int unsigned rn,
                                         input int unsigned rm);
    return {2'b00, 4'h3, rd[3:0], rn[3:0], rm[3:0], 14'd0};
  endfunction

  function automatic logic [31:0] mk_br(input int unsigned f, input logic [25:0] imm);
    return {2'b11, f[3:0], imm};
  endfunction

  task automatic check_ex();
    check("valid", 32'(bus.valid_ex_o), 32'(mex.valid));
    check("opA", bus.opA_ex_o, mex.opA);
    check("opB", bus.opB_ex_o, mex.opB);
    check("ext", bus.Extend_ex_o, mex.ext);
    check("rd_ex", 32'(bus.rd_ex_o), 32'(mex.rd));
    check("func", 32'(bus.alu_func_ex_o), 32'(mex.func));
    check("bsel_ex", 32'(bus.branchselect_ex_o), 32'(mex.bsel));
    check("mem_re", 32'(bus.mem_re_ex_o), 32'(mex.mre));
    check("mem_we", 32'(bus.mem_we_ex_o), 32'(mex.mwe));
    check("reg_we", 32'(bus.reg_we_ex_o), 32'(mex.rwe));
  endtask

  // One pipeline cycle: drive at negedge, check combinational outputs, clock,
  // advance the model and check the registered outputs.
  task automatic step(input logic [31:0] ins, input logic clr, input logic we,
                      input logic [3:0] wrd, input logic [31:0] wd, output logic st);
    ex_t d, nxt;
    logic exp_st;
    @(negedge clk);
    bus.instruction_id_i = ins;
    bus.clear_pipes_i    = clr;
    bus.we_wb_i          = we;
    bus.rd_wb_i          = wrd;
    bus.data_wb_i        = wd;
    m_we = we; m_wrd = wrd; m_wd = wd;
    #1;
    st     = bus.stall_o;
    exp_st = model_stall(ins);
    d      = model_decode(ins);
    check("stall", 32'(st), 32'(exp_st));
    check("bsel_id", 32'(bus.branchselect_id_o), exp_st ? 32'd0 : 32'(d.bsel));
    nxt = (clr || exp_st) ? ex_t'('0) : d;
    @(posedge clk);
    #1;
    mex = nxt;
    if (we && (wrd != 4'd0)) mregs[wrd] = wd;
    check_ex();
  endtask

  task automatic model_reset();
    mex = '0;
    for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
  endtask

  logic st;
  logic [31:0] ins;

  initial begin
    rst_n = 1'b0;
    bus.instruction_id_i = '0;
    bus.clear_pipes_i    = 1'b0;
    bus.we_wb_i          = 1'b0;
    bus.rd_wb_i          = '0;
    bus.data_wb_i        = '0;
    m_we = 1'b0; m_wrd = '0; m_wd = '0;
    model_reset();
    #12;
    check_ex();
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // write-through bypass on rn
    step(mk_alu(1, 3, 0), 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, st);
    check("bypass_opA", bus.opA_ex_o, 32'hDEADBEEF);
    // write to R0 is ignored
    step(32'd0, 1'b0, 1'b1, 4'd0, 32'h12345678, st);
    step(mk_alu(1, 0, 0), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("r0_zero", bus.opA_ex_o, 32'd0);
    // immediates
    step(mk(1, 0, 2, 1, 18'h20000), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("imm18_neg", bus.opB_ex_o, 32'hFFFE0000);
    step(mk_br(4'b0110, 26'd12), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("br_ext", bus.Extend_ex_o, 32'd12);
    check("br_class", 32'(bus.branchselect_ex_o), 32'd2);

    // load-use: one stall cycle then issue
    step(mk(2, 1, 4, 1, 18'd8), 1'b0, 1'b0, 4'd0, 32'd0, st);
    step(mk_alu(5, 4, 2), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("lu_stall", 32'(st), 32'd1);
    check("lu_bubble", 32'(bus.valid_ex_o), 32'd0);
    step(mk_alu(5, 4, 2), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("lu_nostall", 32'(st), 32'd0);
    check("lu_issue", 32'(bus.valid_ex_o), 32'd1);

    // load to R0 never stalls
    step(mk(2, 1, 0, 1, 18'd0), 1'b0, 1'b0, 4'd0, 32'd0, st);
    step(mk_alu(6, 0, 0), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("r0_nostall", 32'(st), 32'd0);
    check("r0_valid", 32'(bus.valid_ex_o), 32'd1);

    // flush during a stall
    step(mk(2, 1, 7, 1, 18'd0), 1'b0, 1'b0, 4'd0, 32'd0, st);
    step(mk_alu(2, 7, 1), 1'b1, 1'b0, 4'd0, 32'd0, st);
    check("fl_stall", 32'(st), 32'd1);
    check("fl_bubble", 32'(bus.valid_ex_o), 32'd0);
    step(mk_alu(2, 7, 1), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("fl_next_valid", 32'(bus.valid_ex_o), 32'd1);

    // NOP stream
    for (int i = 0; i < 5; i++) begin
      step(32'd0, 1'b0, 1'b0, 4'd0, 32'd0, st);
      check("nop_stall", 32'(st), 32'd0);
      check("nop_reg_we", 32'(bus.reg_we_ex_o), 32'd0);
      check("nop_mem", 32'({bus.mem_re_ex_o, bus.mem_we_ex_o}), 32'd0);
    end

    // asynchronous reset in mid-cycle with a valid instruction in EX
    step(32'd0, 1'b0, 1'b1, 4'd5, 32'h00000055, st);
    step(mk_alu(1, 5, 5), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("pre_rst_valid", 32'(bus.valid_ex_o), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_ex();
    check("mid_rst_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk_alu(1, 5, 5), 1'b0, 1'b0, 4'd0, 32'd0, st);
    check("r5_after_rst", bus.opA_ex_o, 32'd0);

    // random traffic; a stalled instruction is held as IF/ID would hold it
    st  = 1'b0;
    ins = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] low;
      int unsigned t, f, rd, rn, rm;
      if (!st) begin
        t   = $urandom_range(0, 3);
        f   = $urandom_range(0, 15);
        rd  = $urandom_range(0, 5);
        rn  = $urandom_range(0, 5);
        rm  = $urandom_range(0, 5);
        low = $urandom;
        ins = {t[1:0], f[3:0], rd[3:0], rn[3:0], rm[3:0], low[13:0]};
        if ($urandom_range(0, 15) == 0) ins = 32'd0;
      end
      step(ins, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 7)), $urandom, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
